// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared constants and enums for the CHIP-8 program loader
package chip8_pkg;

  localparam logic [11:0] LOAD_BASE = 12'h200;
  localparam logic [11:0] MEM_TOP   = 12'hFFF;
  localparam int          BYTE_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_CHECKSUM = 2'd3
  } err_t;

endpackage

// File: rtl/chip8_program_loader_if.sv
// rtl/chip8_program_loader_if.sv - byte source stream plus program RAM port
interface chip8_program_loader_if #(
  parameter int ADDR_W = 12
);
  import chip8_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_wdata;
  logic [BYTE_W-1:0] mem_rdata;

  // master is the loader: it sinks the byte stream and drives the RAM port
  modport master (
    input  in_valid, in_data, in_last, mem_rdata,
    output in_ready, mem_we, mem_re, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, in_last, mem_rdata,
    input  in_ready, mem_we, mem_re, mem_addr, mem_wdata
  );

endinterface

// File: rtl/chip8_loader_checksum.sv
// rtl/chip8_loader_checksum.sv - 16-bit additive byte accumulator
module chip8_loader_checksum
  import chip8_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              add,
  input  logic [BYTE_W-1:0] data,
  output logic [15:0]       value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (add) begin
      value <= value + 16'(data);
    end
  end

endmodule

// File: rtl/chip8_program_loader.sv
// rtl/chip8_program_loader.sv - streams a program image into RAM at LOAD_BASE and verifies it
module chip8_program_loader
  import chip8_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] LOAD_BASE = chip8_pkg::LOAD_BASE,
  parameter int                MAX_BYTES = int'(MEM_TOP) - int'(LOAD_BASE) + 1,
  parameter int                TIMEOUT   = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  chip8_program_loader_if.master bus,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [12:0]            byte_count,
  output logic [15:0]            checksum
);

  localparam int              TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [12:0]     BC_MAX = 13'(MAX_BYTES);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  state_t            state_q, state_nx;
  err_t              err_code_q, err_code_nx;
  logic              in_ready_q, in_ready_nx;
  logic              mem_we_q, mem_we_nx;
  logic              mem_re_q, mem_re_nx;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nx;
  logic [7:0]        mem_wdata_q, mem_wdata_nx;
  logic              cpu_hold_q, cpu_hold_nx;
  logic              done_q, done_nx;
  logic              error_q, error_nx;
  logic [12:0]       byte_count_q, byte_count_nx;
  logic [12:0]       rd_idx_q, rd_idx_nx;
  logic [TW-1:0]     tcnt_q, tcnt_nx;
  logic              re_last_q, re_last_nx;
  logic              data_vld_q, data_last_q, chk_q;
  logic              wsum_clr, wsum_add, rsum_clr;
  logic [15:0]       wsum, rsum;

  chip8_loader_checksum u_wsum (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wsum_clr),
    .add     (wsum_add),
    .data    (bus.in_data),
    .value   (wsum)
  );

  // read data lands one cycle after mem_re, so the read-back sum adds on the delayed strobe
  chip8_loader_checksum u_rsum (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (rsum_clr),
    .add     (data_vld_q),
    .data    (bus.mem_rdata),
    .value   (rsum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      err_code_q   <= ERR_NONE;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      byte_count_q <= '0;
      rd_idx_q     <= '0;
      tcnt_q       <= '0;
      re_last_q    <= 1'b0;
      data_vld_q   <= 1'b0;
      data_last_q  <= 1'b0;
      chk_q        <= 1'b0;
    end else begin
      state_q      <= state_nx;
      err_code_q   <= err_code_nx;
      in_ready_q   <= in_ready_nx;
      mem_we_q     <= mem_we_nx;
      mem_re_q     <= mem_re_nx;
      mem_addr_q   <= mem_addr_nx;
      mem_wdata_q  <= mem_wdata_nx;
      cpu_hold_q   <= cpu_hold_nx;
      done_q       <= done_nx;
      error_q      <= error_nx;
      byte_count_q <= byte_count_nx;
      rd_idx_q     <= rd_idx_nx;
      tcnt_q       <= tcnt_nx;
      re_last_q    <= re_last_nx;
      data_vld_q   <= mem_re_q;
      data_last_q  <= re_last_q;
      chk_q        <= data_last_q;
    end
  end

  always_comb begin
    state_nx      = state_q;
    err_code_nx   = err_code_q;
    mem_we_nx     = 1'b0;
    mem_re_nx     = 1'b0;
    re_last_nx    = 1'b0;
    mem_addr_nx   = mem_addr_q;
    mem_wdata_nx  = mem_wdata_q;
    byte_count_nx = byte_count_q;
    rd_idx_nx     = rd_idx_q;
    tcnt_nx       = tcnt_q;
    wsum_clr      = 1'b0;
    wsum_add      = 1'b0;
    rsum_clr      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_nx      = ST_LOAD;
          err_code_nx   = ERR_NONE;
          byte_count_nx = '0;
          rd_idx_nx     = '0;
          tcnt_nx       = '0;
          wsum_clr      = 1'b1;
          rsum_clr      = 1'b1;
        end
      end

      ST_LOAD: begin
        if (bus.in_valid && in_ready_q) begin
          mem_we_nx     = 1'b1;
          mem_addr_nx   = LOAD_BASE + ADDR_W'(byte_count_q);
          mem_wdata_nx  = bus.in_data;
          byte_count_nx = byte_count_q + 13'd1;
          wsum_add      = 1'b1;
          tcnt_nx       = '0;
          // in_last on the final allowed byte is a full image, not an overflow
          if (bus.in_last) begin
            state_nx = ST_VERIFY;
          end else if (byte_count_q == BC_MAX - 13'd1) begin
            state_nx    = ST_ERROR;
            err_code_nx = ERR_OVERFLOW;
          end
        end else if (tcnt_q == T_LAST) begin
          state_nx    = ST_ERROR;
          err_code_nx = ERR_TIMEOUT;
        end else begin
          tcnt_nx = tcnt_q + TW'(1);
        end
      end

      ST_VERIFY: begin
        // the registered strobe keeps the first read one cycle behind the last write
        if (rd_idx_q < byte_count_q) begin
          mem_re_nx   = 1'b1;
          re_last_nx  = (rd_idx_q == byte_count_q - 13'd1);
          mem_addr_nx = LOAD_BASE + ADDR_W'(rd_idx_q);
          rd_idx_nx   = rd_idx_q + 13'd1;
        end
        if (chk_q) begin
          if (rsum == wsum) begin
            state_nx = ST_DONE;
          end else begin
            state_nx    = ST_ERROR;
            err_code_nx = ERR_CHECKSUM;
          end
        end
      end

      default: state_nx = ST_IDLE;
    endcase

    in_ready_nx = (state_nx == ST_LOAD) && (byte_count_nx < BC_MAX);
    done_nx     = (state_nx == ST_DONE);
    cpu_hold_nx = (state_nx != ST_DONE);
    error_nx    = (state_nx == ST_ERROR);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign byte_count    = byte_count_q;
  assign checksum      = wsum;

endmodule

// File: tb/tb_chip8_program_loader.sv
// tb/tb_chip8_program_loader.sv - self-checking bench for chip8_program_loader
module tb_chip8_program_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_b = 1'b0;
  logic start_s = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic sel = 1'b0;
  logic corrupt = 1'b0;
  logic both_seen = 1'b0;
  logic acc_ok = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [7:0] ram [0:4095];
  logic [11:0] wlog_a [$];
  logic [7:0] wlog_d [$];
  logic [7:0] img [$];
  int rd_cnt = 0;
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chip8_program_loader_if #(.ADDR_W(12)) if_b ();
  chip8_program_loader_if #(.ADDR_W(12)) if_s ();

  logic b_cpu_hold, b_done, b_error, s_cpu_hold, s_done, s_error;
  logic [1:0] b_err_code, s_err_code;
  logic [12:0] b_byte_count, s_byte_count;
  logic [15:0] b_checksum, s_checksum;

  assign if_b.in_valid  = in_valid;
  assign if_b.in_data   = in_data;
  assign if_b.in_last   = in_last;
  assign if_b.mem_rdata = rdata;
  assign if_s.in_valid  = in_valid;
  assign if_s.in_data   = in_data;
  assign if_s.in_last   = in_last;
  assign if_s.mem_rdata = rdata;

  chip8_program_loader #(.TIMEOUT(100)) u_big (
    .clk(clk), .reset_n(reset_n), .start(start_b), .bus(if_b),
    .cpu_hold(b_cpu_hold), .done(b_done), .error(b_error), .err_code(b_err_code),
    .byte_count(b_byte_count), .checksum(b_checksum)
  );

  chip8_program_loader #(.MAX_BYTES(8), .TIMEOUT(100)) u_small (
    .clk(clk), .reset_n(reset_n), .start(start_s), .bus(if_s),
    .cpu_hold(s_cpu_hold), .done(s_done), .error(s_error), .err_code(s_err_code),
    .byte_count(s_byte_count), .checksum(s_checksum)
  );

  logic o_in_ready, o_cpu_hold, o_done, o_error, m_we, m_re;
  logic [1:0] o_err_code;
  logic [12:0] o_byte_count;
  logic [15:0] o_checksum;
  logic [11:0] m_addr;
  logic [7:0] m_wdata;

  assign o_in_ready   = sel ? if_s.in_ready  : if_b.in_ready;
  assign o_cpu_hold   = sel ? s_cpu_hold     : b_cpu_hold;
  assign o_done       = sel ? s_done         : b_done;
  assign o_error      = sel ? s_error        : b_error;
  assign o_err_code   = sel ? s_err_code     : b_err_code;
  assign o_byte_count = sel ? s_byte_count   : b_byte_count;
  assign o_checksum   = sel ? s_checksum     : b_checksum;
  assign m_we         = sel ? if_s.mem_we    : if_b.mem_we;
  assign m_re         = sel ? if_s.mem_re    : if_b.mem_re;
  assign m_addr       = sel ? if_s.mem_addr  : if_b.mem_addr;
  assign m_wdata      = sel ? if_s.mem_wdata : if_b.mem_wdata;

  // RAM model: synchronous write, one-cycle read latency, optional corruption of 0x20B on read
  always @(posedge clk) begin
    if (m_we) begin
      ram[m_addr] <= m_wdata;
      wlog_a.push_back(m_addr);
      wlog_d.push_back(m_wdata);
    end
    if (m_re) begin
      rdata <= ram[m_addr] + ((corrupt && m_addr == 12'h20B) ? 8'd1 : 8'd0);
      rd_cnt++;
    end
    if (m_we && m_re) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(img[i]);
    return 16'(s);
  endfunction

  function automatic logic model_verifies(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = img[i];
      if (corrupt && i == 11) b = b + 8'd1;
      s += int'(b);
    end
    return 16'(s) == model_sum(n);
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1;
    if (sel) start_s = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    start_b = 1'b0;
    wlog_a.delete();
    wlog_d.delete();
    rd_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap, input int lim);
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    acc_ok = 1'b0;
    for (int k = 0; k < lim && !acc_ok; k++) begin
      @(negedge clk);
      if (o_in_ready) begin
        @(posedge clk); #1;
        acc_ok = 1'b1;
      end
    end
    if (!acc_ok) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_all(input logic with_last, input int n, input int max_gap);
    for (int i = 0; i < n; i++)
      send_byte(img[i], with_last && (i == n - 1), int'($urandom_range(max_gap, 0)), 40);
  endtask

  task automatic wait_end(input string tag, input int limit);
    int k = 0;
    while (!(o_done || o_error) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({tag, " terminates"}, 32'(k < limit), 32'd1);
  endtask

  task automatic expect_result(input string tag, input int n, input logic exp_done,
                               input logic [1:0] exp_code, input int exp_reads);
    check({tag, " byte_count"}, 32'(o_byte_count), n);
    check({tag, " checksum"}, 32'(o_checksum), 32'(model_sum(n)));
    check({tag, " writes"}, wlog_a.size(), n);
    for (int i = 0; i < n && i < wlog_a.size(); i++) begin
      check({tag, " waddr"}, 32'(wlog_a[i]), 32'h200 + i);
      check({tag, " wdata"}, 32'(wlog_d[i]), 32'(img[i]));
    end
    check({tag, " reads"}, rd_cnt, exp_reads);
    check({tag, " done"}, 32'(o_done), 32'(exp_done));
    check({tag, " error"}, 32'(o_error), 32'(!exp_done));
    check({tag, " err_code"}, 32'(o_err_code), 32'(exp_code));
    check({tag, " cpu_hold"}, 32'(o_cpu_hold), 32'(!exp_done));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " cpu_hold"}, 32'(o_cpu_hold), 32'd1);
    check({tag, " done"}, 32'(o_done), 32'd0);
    check({tag, " error"}, 32'(o_error), 32'd0);
    check({tag, " err_code"}, 32'(o_err_code), 32'd0);
    check({tag, " byte_count"}, 32'(o_byte_count), 32'd0);
    check({tag, " checksum"}, 32'(o_checksum), 32'd0);
    check({tag, " in_ready"}, 32'(o_in_ready), 32'd0);
    check({tag, " mem_we"}, 32'(m_we), 32'd0);
    check({tag, " mem_re"}, 32'(m_re), 32'd0);
    check({tag, " mem_addr"}, 32'(m_addr), 32'd0);
  endtask

  initial begin
    logic ok_model;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset big");
    check("reset small cpu_hold", 32'(s_cpu_hold), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // store-registers test program
    img = '{8'h60, 8'hEA, 8'h61, 8'hAC, 8'h62, 8'hAA, 8'h63, 8'hE9, 8'hA0,
            8'h00, 8'hF3, 8'h55, 8'hA0, 8'h00, 8'h60, 8'h00, 8'hD0, 8'h04};
    pulse_start();
    send_all(1'b1, 18, 0);
    wait_end("prog", 200);
    ok_model = model_verifies(18);
    expect_result("prog", 18, ok_model, ok_model ? 2'd0 : 2'd3, 18);
    check("prog checksum const", 32'(o_checksum), 32'h086B);

    img = '{8'h00, 8'hE0};
    pulse_start();
    check("reload cpu_hold", 32'(o_cpu_hold), 32'd1);
    check("reload done", 32'(o_done), 32'd0);
    send_all(1'b1, 2, 1);
    wait_end("reload", 100);
    expect_result("reload", 2, 1'b1, 2'd0, 2);
    check("reload checksum const", 32'(o_checksum), 32'h00E0);

    img = '{8'h60, 8'hEA, 8'h61, 8'hAC, 8'h62, 8'hAA, 8'h63, 8'hE9, 8'hA0,
            8'h00, 8'hF3, 8'h55, 8'hA0, 8'h00, 8'h60, 8'h00, 8'hD0, 8'h04};
    corrupt = 1'b1;
    pulse_start();
    send_all(1'b1, 18, 1);
    wait_end("corrupt", 200);
    ok_model = model_verifies(18);
    expect_result("corrupt", 18, ok_model, ok_model ? 2'd0 : 2'd3, 18);
    corrupt = 1'b0;

    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(40, 1));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      pulse_start();
      send_all(1'b1, n, 2);
      wait_end("random", 400);
      expect_result("random", n, 1'b1, 2'd0, n);
    end

    img.delete();
    for (int i = 0; i < 5; i++) img.push_back(8'($urandom));
    pulse_start();
    send_all(1'b0, 5, 1);
    wait_end("timeout", 300);
    expect_result("timeout", 5, 1'b0, 2'd2, 0);
    repeat (20) @(negedge clk);
    check("timeout no late writes", wlog_a.size(), 5);

    sel = 1'b1;
    img.delete();
    for (int i = 0; i < 9; i++) img.push_back(8'($urandom));
    pulse_start();
    send_all(1'b0, 8, 1);
    check("ovf 8th accepted", 32'(acc_ok), 32'd1);
    @(negedge clk);
    check("ovf in_ready after 8th", 32'(o_in_ready), 32'd0);
    @(posedge clk); #1;
    send_byte(img[8], 1'b0, 0, 10);
    check("ovf 9th refused", 32'(acc_ok), 32'd0);
    expect_result("ovf", 8, 1'b0, 2'd1, 0);

    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    pulse_start();
    send_all(1'b1, 8, 1);
    wait_end("full", 100);
    expect_result("full", 8, 1'b1, 2'd0, 8);

    sel = 1'b0;
    img.delete();
    for (int i = 0; i < 6; i++) img.push_back(8'($urandom));
    pulse_start();
    send_all(1'b0, 3, 0);
    reset_n = 1'b0;
    in_valid = 1'b1;
    in_data = img[3];
    @(negedge clk);
    check_idle("midreset");
    repeat (5) @(negedge clk);
    check("midreset writes", wlog_a.size(), 2);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post reset writes", wlog_a.size(), 2);
    check_idle("post reset");
    in_valid = 1'b0;

    check("we re exclusive", 32'(both_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
